// File: rtl/register_sequencer.sv
// Purpose:      expands LOAD / CLEAR / INC-by-N / DEC-by-N commands into single-cycle
//               load/inc/dec/clr pulses for a downstream register, saturating at 0 / all-ones.
// Latency:      LOAD/CLEAR act in cycle 1 and finish (done) in cycle 2; INC/DEC N pulse in
//               cycles 1..N and finish in cycle N+1 (one extra empty cycle when saturating).
// Backpressure: cmd_ready is high only in IDLE, so one command is in flight at a time;
//               a new command can be accepted on the edge that ends the done cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_op (00 LOAD, 01 INC, 10 DEC, 11 CLEAR)
//   cmd_data                 LOAD value, or repeat count in the low COUNT_SIZE bits
//   reg_value                current output of the downstream register
//   reg_in                   registered LOAD value driven to the register
//   reg_load/inc/dec/clr     register controls, at most one high per cycle
//   done                     one-cycle completion pulse
//   sat                      last step command stopped early at a limit
module register_sequencer #(
  parameter int DATA_SIZE  = 11,
  parameter int COUNT_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [DATA_SIZE-1:0] cmd_data,
  input  logic [DATA_SIZE-1:0] reg_value,
  output logic [DATA_SIZE-1:0] reg_in,
  output logic                 reg_load,
  output logic                 reg_inc,
  output logic                 reg_dec,
  output logic                 reg_clr,
  output logic                 done,
  output logic                 sat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STEP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [COUNT_SIZE-1:0] REM_ONE = {{(COUNT_SIZE-1){1'b0}}, 1'b1};

  state_t                state;
  logic [1:0]            op;
  logic [COUNT_SIZE-1:0] rem;
  logic                  at_limit;
  logic                  step_go;

  // Limit check looks at the live register value, so a pulse is never
  // issued when it would wrap the register.
  always_comb begin
    at_limit = 1'b0;
    if (op == OP_INC) begin
      at_limit = &reg_value;
    end else begin
      at_limit = (reg_value == '0);
    end
  end

  assign step_go   = (state == S_STEP) && (rem != '0) && !at_limit;
  assign reg_inc   = step_go && (op == OP_INC);
  assign reg_dec   = step_go && (op == OP_DEC);
  assign reg_load  = (state == S_LOAD);
  assign reg_clr   = (state == S_CLEAR);
  // Gated with rst so the port reads 0 during reset even before the first edge.
  assign cmd_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op     <= OP_LOAD;
      rem    <= '0;
      reg_in <= '0;
      done   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless a transition below re-asserts it.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op  <= cmd_op;
            rem <= cmd_data[COUNT_SIZE-1:0];
            sat <= 1'b0;
            case (cmd_op)
              OP_LOAD: begin
                reg_in <= cmd_data;
                state  <= S_LOAD;
              end
              OP_CLEAR: state <= S_CLEAR;
              default:  state <= S_STEP;
            endcase
          end
        end
        S_LOAD: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        S_CLEAR: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        S_STEP: begin
          if (rem == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
            sat   <= 1'b0;
          end else if (at_limit) begin
            // Stopped short: this cycle carries no pulse.
            state <= S_IDLE;
            done  <= 1'b1;
            sat   <= 1'b1;
          end else begin
            rem <= rem - REM_ONE;
            if (rem == REM_ONE) begin
              state <= S_IDLE;
              done  <= 1'b1;
              sat   <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_sequencer.sv
module tb_register_sequencer;

  localparam int DS = 11;
  localparam int CS = 4;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DS-1:0] cmd_data;
  logic [DS-1:0] reg_value;
  logic [DS-1:0] reg_in;
  logic          reg_load;
  logic          reg_inc;
  logic          reg_dec;
  logic          reg_clr;
  logic          done;
  logic          sat;

  int errors = 0;
  int checks = 0;

  register_sequencer #(.DATA_SIZE(DS), .COUNT_SIZE(CS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .reg_value (reg_value),
    .reg_in    (reg_in),
    .reg_load  (reg_load),
    .reg_inc   (reg_inc),
    .reg_dec   (reg_dec),
    .reg_clr   (reg_clr),
    .done      (done),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register model: wraps freely, so any missed saturation shows up.
  logic [DS-1:0] q = '0;
  always @(posedge clk) begin
    if (reg_clr)       q <= '0;
    else if (reg_load) q <= reg_in;
    else if (reg_inc)  q <= q + 1'b1;
    else if (reg_dec)  q <= q - 1'b1;
  end
  assign reg_value = q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, check it is accepted, and return in cycle 1 after accept.
  task automatic send(input logic [1:0] op, input int data);
    chk("ready_before_send", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = DS'(data);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
  endtask

  function automatic logic [31:0] ctl();
    return {28'd0, reg_load, reg_inc, reg_dec, reg_clr};
  endfunction

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;

    // Reset state
    #2;
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_sat",   32'(sat), 0);
    chk("rst_reg_in", 32'(reg_in), 0);
    chk("rst_ctl",   ctl(), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 1);

    // 1: LOAD 10
    send(OP_LOAD, 10);
    chk("t1_load",   ctl(), 32'b1000);
    chk("t1_reg_in", 32'(reg_in), 10);
    chk("t1_busy",   32'(cmd_ready), 0);
    chk("t1_nodone", 32'(done), 0);
    tick();
    chk("t1_done",   32'(done), 1);
    chk("t1_ctl0",   ctl(), 0);
    chk("t1_ready",  32'(cmd_ready), 1);
    chk("t1_value",  32'(reg_value), 10);

    // 2: INC 3 -> 13
    send(OP_INC, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_inc",    ctl(), 32'b0100);
      chk("t2_busy",   32'(cmd_ready), 0);
      chk("t2_nodone", 32'(done), 0);
      tick();
    end
    chk("t2_ctl0",  ctl(), 0);
    chk("t2_done",  32'(done), 1);
    chk("t2_sat",   32'(sat), 0);
    chk("t2_value", 32'(reg_value), 13);

    // 3: DEC 0 -> no pulse, done in cycle 2 (back-to-back accept in done cycle)
    send(OP_DEC, 0);
    chk("t3_ctl0",   ctl(), 0);
    chk("t3_nodone", 32'(done), 0);
    tick();
    chk("t3_done",  32'(done), 1);
    chk("t3_sat",   32'(sat), 0);
    chk("t3_value", 32'(reg_value), 13);

    // 4: LOAD 2046, INC 5 -> one pulse, saturates at 2047
    send(OP_LOAD, 2046);
    chk("t4_load", ctl(), 32'b1000);
    tick();
    chk("t4_load_done", 32'(done), 1);
    send(OP_INC, 5);
    chk("t4_inc1", ctl(), 32'b0100);
    tick();
    chk("t4_limit_ctl0", ctl(), 0);
    chk("t4_limit_nodone", 32'(done), 0);
    chk("t4_limit_value", 32'(reg_value), 2047);
    tick();
    chk("t4_done",  32'(done), 1);
    chk("t4_sat",   32'(sat), 1);
    chk("t4_value", 32'(reg_value), 2047);
    tick();
    chk("t4_done_pulse", 32'(done), 0);
    chk("t4_sat_hold",   32'(sat), 1);

    // 5: LOAD 2, DEC 4 -> two pulses, saturates at 0; then CLEAR
    send(OP_LOAD, 2);
    tick();
    chk("t5_load_done", 32'(done), 1);
    send(OP_DEC, 4);
    chk("t5_dec1", ctl(), 32'b0010);
    tick();
    chk("t5_dec2", ctl(), 32'b0010);
    tick();
    chk("t5_limit_ctl0", ctl(), 0);
    chk("t5_limit_value", 32'(reg_value), 0);
    tick();
    chk("t5_done",  32'(done), 1);
    chk("t5_sat",   32'(sat), 1);
    chk("t5_value", 32'(reg_value), 0);
    send(OP_CLEAR, 0);
    chk("t5_clr",       ctl(), 32'b0001);
    chk("t5_sat_clear", 32'(sat), 0);
    tick();
    chk("t5_clr_done", 32'(done), 1);
    chk("t5_clr_ctl0", ctl(), 0);

    // 6: INC 10 from 0, reset after 3rd pulse
    send(OP_INC, 10);
    for (int i = 0; i < 3; i++) begin
      chk("t6_inc", ctl(), 32'b0100);
      tick();
    end
    chk("t6_inc4_pending", ctl(), 32'b0100);
    rst = 1'b1;
    #1;
    chk("t6_rst_ctl0",   ctl(), 0);
    chk("t6_rst_ready",  32'(cmd_ready), 0);
    chk("t6_rst_done",   32'(done), 0);
    chk("t6_rst_reg_in", 32'(reg_in), 0);
    chk("t6_value",      32'(reg_value), 3);
    tick();
    chk("t6_rst_hold_done", 32'(done), 0);
    rst = 1'b0;
    #1;
    chk("t6_release_ready", 32'(cmd_ready), 1);
    tick();
    chk("t6_no_done", 32'(done), 0);
    chk("t6_idle_ctl0", ctl(), 0);
    send(OP_LOAD, 5);
    chk("t6_load",   ctl(), 32'b1000);
    chk("t6_reg_in", 32'(reg_in), 5);
    tick();
    chk("t6_done",  32'(done), 1);
    chk("t6_final", 32'(reg_value), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
